// File: rtl/mm_pkg.sv
// Shared types and defaults for the streaming matrix multiplier.
package mm_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_MAX_DIM = 4;
    localparam int DEF_OUT_W   = 12;

    typedef enum logic [2:0] {
        StLoadA,
        StLoadB,
        StCheck,
        StCalc,
        StOut,
        StIllegal,
        StDone
    } state_t;

    // Wide enough to sum MAX_DIM full-scale products without wrapping.
    function automatic int acc_width(input int data_w, input int max_dim);
        return 2 * data_w + $clog2(max_dim);
    endfunction

endpackage

// File: rtl/mm_mac.sv
// Multiply-accumulate with output range check; `MM_SAT_EN selects saturation instead of wrap.
module mm_mac
    import mm_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_DIM = DEF_MAX_DIM,
    parameter int OUT_W   = DEF_OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [OUT_W-1:0]  result,
    output logic              overflow
);

    localparam int ACC_W = acc_width(DATA_W, MAX_DIM);
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       too_high, too_low;

    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = clr ? prod_ext : acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign too_high = acc_q > OUT_MAX;
    assign too_low  = acc_q < OUT_MIN;
    assign overflow = too_high || too_low;

`ifdef MM_SAT_EN
    always_comb begin
        result = acc_q[OUT_W-1:0];
        if (too_high) begin
            result = OUT_MAX[OUT_W-1:0];
        end else if (too_low) begin
            result = OUT_MIN[OUT_W-1:0];
        end
    end
`else
    assign result = acc_q[OUT_W-1:0];
`endif

endmodule

// File: rtl/mm_gen2.sv
// Streaming matrix multiplier: loads A then B row-major, checks dimensions, emits A*B row-major.
// Optional saturation of results is enabled by defining MM_SAT_EN (see mm_mac).
module mm_gen2
    import mm_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_DIM = DEF_MAX_DIM,
    parameter int OUT_W   = DEF_OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              col_end,
    input  logic              row_end,
    input  logic              out_ready,
    output logic              busy,
    output logic              valid,
    output logic [OUT_W-1:0]  out_data,
    output logic              change_row,
    output logic              is_legal,
    output logic              overflow,
    output logic              done
);

    localparam int CW = $clog2(MAX_DIM + 2);
    localparam int IW = $clog2(MAX_DIM * MAX_DIM);
    localparam logic [CW-1:0] MD  = CW'(MAX_DIM);
    localparam logic [CW-1:0] ONE = CW'(1);

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem_a [MAX_DIM*MAX_DIM];
    logic [DATA_W-1:0] mem_b [MAX_DIM*MAX_DIM];

    logic [CW-1:0] cur_row_q, cur_col_q, cols_ld_q;
    logic [CW-1:0] rows_a_q, cols_a_q, rows_b_q, cols_b_q;
    logic [CW-1:0] i_q, j_q, k_q;
    logic          bad_q;

    logic          accept, end_of_row, in_range, row_mismatch;
    logic [CW-1:0] row_len, cols_now, rows_now, col_next;
    logic [IW-1:0] widx, idx_a, idx_b;
    logic          last_i, last_j, last_k, dims_ok;
    logic [OUT_W-1:0] mac_result;
    logic          mac_ovf;

    // Load-side bookkeeping
    assign accept       = in_valid && (state_q == StLoadA || state_q == StLoadB);
    assign end_of_row   = col_end || row_end;
    assign in_range     = (cur_row_q < MD) && (cur_col_q < MD);
    assign row_len      = cur_col_q + ONE;
    assign cols_now     = (cur_row_q == '0) ? row_len : cols_ld_q;
    assign row_mismatch = end_of_row && (cur_row_q != '0) && (row_len != cols_ld_q);
    assign rows_now     = (cur_row_q == MD) ? MD : cur_row_q + ONE;
    assign col_next     = (cur_col_q == MD) ? MD : cur_col_q + ONE;
    assign widx         = IW'(int'(cur_row_q) * MAX_DIM + int'(cur_col_q));

    always_ff @(posedge clk) begin
        if (accept && in_range) begin
            if (state_q == StLoadA) begin
                mem_a[widx] <= in_data;
            end else begin
                mem_b[widx] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_row_q <= '0;
            cur_col_q <= '0;
            cols_ld_q <= '0;
            bad_q     <= 1'b0;
            rows_a_q  <= '0;
            cols_a_q  <= '0;
            rows_b_q  <= '0;
            cols_b_q  <= '0;
        end else if (state_q == StDone) begin
            cur_row_q <= '0;
            cur_col_q <= '0;
            cols_ld_q <= '0;
            bad_q     <= 1'b0;
            rows_a_q  <= '0;
            cols_a_q  <= '0;
            rows_b_q  <= '0;
            cols_b_q  <= '0;
        end else if (accept) begin
            // Out-of-range writes are dropped above; just remember the matrix is unusable.
            if (!in_range || row_mismatch) begin
                bad_q <= 1'b1;
            end
            if (row_end) begin
                cur_row_q <= '0;
                cur_col_q <= '0;
                cols_ld_q <= '0;
                if (state_q == StLoadA) begin
                    rows_a_q <= rows_now;
                    cols_a_q <= cols_now;
                end else begin
                    rows_b_q <= rows_now;
                    cols_b_q <= cols_now;
                end
            end else if (end_of_row) begin
                cur_col_q <= '0;
                cur_row_q <= rows_now;
                if (cur_row_q == '0) begin
                    cols_ld_q <= row_len;
                end
            end else begin
                cur_col_q <= col_next;
            end
        end
    end

    // Compute-side indexing
    assign last_i  = i_q == rows_a_q - ONE;
    assign last_j  = j_q == cols_b_q - ONE;
    assign last_k  = k_q == cols_a_q - ONE;
    assign dims_ok = !bad_q && (cols_a_q == rows_b_q)
                     && (rows_a_q <= MD) && (cols_a_q <= MD) && (cols_b_q <= MD)
                     && (rows_a_q != '0) && (cols_a_q != '0) && (cols_b_q != '0);
    assign idx_a   = IW'(int'(i_q) * MAX_DIM + int'(k_q));
    assign idx_b   = IW'(int'(k_q) * MAX_DIM + int'(j_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else if (state_q == StCalc) begin
            k_q <= last_k ? '0 : k_q + ONE;
        end else if (state_q == StOut && out_ready) begin
            if (last_j) begin
                j_q <= '0;
                i_q <= i_q + ONE;
            end else begin
                j_q <= j_q + ONE;
            end
        end else if (state_q == StCheck || state_q == StDone) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end
    end

    mm_mac #(
        .DATA_W  (DATA_W),
        .MAX_DIM (MAX_DIM),
        .OUT_W   (OUT_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q == StCalc),
        .clr      (k_q == '0),
        .a        (mem_a[idx_a]),
        .b        (mem_b[idx_b]),
        .result   (mac_result),
        .overflow (mac_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLoadA;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoadA:   if (accept && row_end) state_d = StLoadB;
            StLoadB:   if (accept && row_end) state_d = StCheck;
            StCheck:   state_d = dims_ok ? StCalc : StIllegal;
            StCalc:    if (last_k) state_d = StOut;
            StOut:     if (out_ready) state_d = (last_i && last_j) ? StDone : StCalc;
            StIllegal: if (out_ready) state_d = StDone;
            StDone:    state_d = StLoadA;
            default:   state_d = StLoadA;
        endcase
    end

    always_comb begin
        busy       = !(state_q == StLoadA || state_q == StLoadB);
        valid      = (state_q == StOut) || (state_q == StIllegal);
        out_data   = (state_q == StOut) ? mac_result : '0;
        change_row = (state_q == StOut) && last_j;
        is_legal   = state_q != StIllegal;
        overflow   = (state_q == StOut) && mac_ovf;
        done       = state_q == StDone;
    end

endmodule

// File: tb/tb_mm_gen2.sv
// Scoreboard bench for mm_gen2: directed matrices, expected results queued, monitor checks transfers.
module tb_mm_gen2;

    logic        clk, rst;
    logic        in_valid, col_end, row_end, out_ready;
    logic [7:0]  in_data;
    logic        busy, valid, change_row, is_legal, overflow, done;
    logic [11:0] out_data;

    typedef struct {
        int data;
        bit cr;
        bit lg;
        bit ov;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   xfer_cyc[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

`ifdef MM_SAT_EN
    localparam int OVF_EXP = 2047;
`else
    localparam int OVF_EXP = -1020;
`endif

    mm_gen2 #(
        .DATA_W  (8),
        .MAX_DIM (4),
        .OUT_W   (12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .col_end    (col_end),
        .row_end    (row_end),
        .out_ready  (out_ready),
        .busy       (busy),
        .valid      (valid),
        .out_data   (out_data),
        .change_row (change_row),
        .is_legal   (is_legal),
        .overflow   (overflow),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic exp_push(input int d, input bit cr, input bit lg, input bit ov);
        exp_t t;
        t.data = d;
        t.cr   = cr;
        t.lg   = lg;
        t.ov   = ov;
        sb.push_back(t);
    endtask

    // Monitor: compares every presented result against the queue head, pops on transfer.
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got out_data=%0d, expected no result",
                         $signed(out_data));
            end else begin
                mon_e = sb[0];
                chk("out_data", $signed(out_data), mon_e.data);
                chk("change_row", change_row, mon_e.cr);
                chk("is_legal", is_legal, mon_e.lg);
                chk("overflow", overflow, mon_e.ov);
                if (out_ready) begin
                    void'(sb.pop_front());
                    xfer_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic send_elem(input int v, input bit ce, input bit re);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'(v);
        col_end  = ce;
        row_end  = re;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        col_end  = 1'b0;
        row_end  = 1'b0;
    endtask

    task automatic send_row(input int n, input int a0, input int a1, input int a2,
                            input int a3, input int a4, input bit last);
        int v;
        for (int c = 0; c < n; c++) begin
            case (c)
                0: v = a0;
                1: v = a1;
                2: v = a2;
                3: v = a3;
                default: v = a4;
            endcase
            send_elem(v, c == n - 1, last && (c == n - 1));
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
        if (done) begin
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("busy_after_done", busy, 0);
        end
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_change_row"}, change_row, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_is_legal"}, is_legal, 1);
    endtask

    task automatic send_ab_2x2();
        send_row(2, 1, 2, 0, 0, 0, 1'b0);
        send_row(2, 3, 4, 0, 0, 0, 1'b1);
        send_row(2, 5, 6, 0, 0, 0, 1'b0);
        send_row(2, 7, 8, 0, 0, 0, 1'b1);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        col_end = 1'b0;
        row_end = 1'b0;
        out_ready = 1'b1;
        #1;
        chk_idle_outputs("in_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_idle_outputs("after_reset");

        // Basic 2x2 product, out_ready high: one result every 3 cycles
        xfer_cyc.delete();
        exp_push(19, 0, 1, 0);
        exp_push(22, 1, 1, 0);
        exp_push(43, 0, 1, 0);
        exp_push(50, 1, 1, 0);
        send_ab_2x2();
        chk("busy_after_b", busy, 1);
        wait_done(100);
        chk("xfer_count", xfer_cyc.size(), 4);
        if (xfer_cyc.size() == 4) begin
            for (int r = 1; r < 4; r++) chk("result_spacing", xfer_cyc[r] - xfer_cyc[r-1], 3);
        end

        // colsA != rowsB
        exp_push(0, 0, 0, 0);
        send_row(3, 1, 2, 3, 0, 0, 1'b0);
        send_row(3, 4, 5, 6, 0, 0, 1'b1);
        send_row(2, 1, 0, 0, 0, 0, 1'b0);
        send_row(2, 0, 1, 0, 0, 0, 1'b1);
        idle();
        wait_done(50);

        // Inconsistent row length in A
        exp_push(0, 0, 0, 0);
        send_row(2, 1, 2, 0, 0, 0, 1'b0);
        send_row(1, 3, 0, 0, 0, 0, 1'b1);
        send_row(1, 1, 0, 0, 0, 0, 1'b0);
        send_row(1, 1, 0, 0, 0, 0, 1'b1);
        idle();
        wait_done(50);

        // Row wider than MAX_DIM
        exp_push(0, 0, 0, 0);
        send_row(5, 1, 2, 3, 4, 5, 1'b1);
        send_row(1, 1, 0, 0, 0, 0, 1'b1);
        idle();
        wait_done(50);

        // Overflow: 4 * 127 * 127 = 64516
        exp_push(OVF_EXP, 1, 1, 1);
        send_row(4, 127, 127, 127, 127, 0, 1'b1);
        for (int r = 0; r < 4; r++) send_row(1, 127, 0, 0, 0, 0, r == 3);
        idle();
        wait_done(50);

        // Back-pressure on the first result of A * I
        out_ready = 1'b0;
        exp_push(1, 0, 1, 0);
        exp_push(2, 1, 1, 0);
        exp_push(3, 0, 1, 0);
        exp_push(4, 1, 1, 0);
        send_row(2, 1, 2, 0, 0, 0, 1'b0);
        send_row(2, 3, 4, 0, 0, 0, 1'b1);
        send_row(2, 1, 0, 0, 0, 0, 1'b0);
        send_row(2, 0, 1, 0, 0, 0, 1'b1);
        idle();
        begin
            int n = 0;
            while (!valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("stall_valid_seen", valid, 1);
        end
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done(100);

        // Reset during CALC aborts; a fresh 1x1 product follows
        send_ab_2x2();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_idle_outputs("mid_calc_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_push(-12, 1, 1, 0);
        send_row(1, 3, 0, 0, 0, 0, 1'b1);
        send_row(1, -4, 0, 0, 0, 0, 1'b1);
        idle();
        wait_done(50);

        // Input activity while busy must not disturb the 2x2 product
        exp_push(19, 0, 1, 0);
        exp_push(22, 1, 1, 0);
        exp_push(43, 0, 1, 0);
        exp_push(50, 1, 1, 0);
        send_ab_2x2();
        for (int r = 0; r < 8; r++) begin
            @(posedge clk);
            #1;
            in_valid = busy;
            in_data  = 8'($urandom);
            col_end  = 1'b1;
            row_end  = 1'b1;
        end
        idle();
        wait_done(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mm_gen2.md
MM_GEN2 -- requirements
Module: mm_gen2

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed element width.
REQ-002 SHALL have parameter MAX_DIM, default 4, max rows/cols per matrix (2..8).
REQ-003 SHALL have parameter OUT_W, default 12, signed result width (OUT_W <= 2*DATA_W+$clog2(MAX_DIM)).
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1, in_data/col_end/row_end qualifier.
REQ-007 SHALL have port in_data, input, DATA_W, signed element, row-major.
REQ-008 SHALL have port col_end, input, 1, last element of current row.
REQ-009 SHALL have port row_end, input, 1, last element of current matrix (always with col_end).
REQ-010 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-011 SHALL have port busy, output, 1, inputs ignored while high.
REQ-012 SHALL have port valid, output, 1, out_data/flags valid.
REQ-013 SHALL have port out_data, output, OUT_W, signed result element.
REQ-014 SHALL have port change_row, output, 1, marks last element of a result row.
REQ-015 SHALL have port is_legal, output, 1, dimension check result, stable with valid.
REQ-016 SHALL have port overflow, output, 1, current out_data exceeded OUT_W range.
REQ-017 SHALL have port done, output, 1, one-cycle pulse after final result accepted.

Function
REQ-018 SHALL use states LOAD_A, LOAD_B, CHECK, CALC, OUT, ILLEGAL, DONE.
REQ-019 LOAD_A/LOAD_B SHALL store element on in_valid; col_count latched from first col_end; row count incremented per col_end; row_end advances LOAD_A->LOAD_B, LOAD_B->CHECK.
REQ-020 busy SHALL rise the cycle after B's row_end and fall on entering LOAD_A.
REQ-021 CHECK (1 cycle) SHALL go CALC if colsA==rowsB and all dims <= MAX_DIM, else ILLEGAL.
REQ-022 Element count > MAX_DIM*MAX_DIM or inconsistent row length SHALL mark illegal; excess writes discarded.
REQ-023 CALC SHALL perform one MAC per cycle, K=colsA cycles per result, accumulator width 2*DATA_W+$clog2(MAX_DIM), cleared at start of each result.
REQ-024 OUT SHALL hold valid high with stable outputs until out_ready; transfer on valid&&out_ready.
REQ-025 Results SHALL emit in row-major order (i outer, j inner); change_row high with element j==colsB-1.
REQ-026 After transfer: next result -> CALC; last result -> DONE.
REQ-027 ILLEGAL SHALL present valid=1, is_legal=0, out_data=0 until out_ready, then DONE.
REQ-028 DONE SHALL pulse done for one cycle, clear dims/counters, go LOAD_A.
REQ-029 Latency per result SHALL be K cycles CALC + 1 cycle to valid, given out_ready high.
REQ-030 overflow SHALL be set when accumulator outside [-2^(OUT_W-1), 2^(OUT_W-1)-1].

Reset
REQ-031 rst SHALL force LOAD_A, clear counters/dims; busy, valid, change_row, overflow, done, out_data = 0; is_legal = 1.
REQ-032 rst mid-load or mid-calc SHALL abort without emitting a result; matrix storage needs no reset.

Configuration
REQ-033 With MM_SAT_EN defined, out_data SHALL saturate to max/min on overflow.
REQ-034 Without MM_SAT_EN, out_data SHALL be the low OUT_W bits (wrap); overflow still reported.

Structure
REQ-035 State enum, default parameters and accumulator-width function SHALL live in package mm_pkg.
REQ-036 MAC datapath (multiply, accumulate, range check, saturation) SHALL be sub-module mm_mac.

Verification
REQ-037 A=[1 2;3 4], B=[5 6;7 8], out_ready=1 -> 19,22(change_row),43,50(change_row), done; each result 3 cycles apart.
REQ-038 A=2x3, B=2x2 -> single valid with is_legal=0, out_data=0, then done; busy falls.
REQ-039 A=1x4 all 127, B=4x1 all 127 (16129*4=64516) -> overflow=1; out_data=2047 with MM_SAT_EN, 64516 mod 4096 = 3076 -> -1020 without.
REQ-040 A=[1 2;3 4], B=I, out_ready low 5 cycles on first result -> out_data=1 held stable, no result lost, order 1,2,3,4.
REQ-041 rst asserted during CALC of first result -> all outputs 0 next cycle; new 1x1*1x1 (3*-4) -> -12, done.
REQ-042 in_valid pulses while busy -> ignored; results unchanged versus REQ-037.
